// File: rtl/serial_or_reducer.sv
// rtl/serial_or_reducer.sv - OR-reduces FRAME_LEN handshaked serial bits into one result bit.
// Optional first-one index output enabled by SERIAL_OR_REDUCER_FIRST_IDX_EN.
module serial_or_reducer #(
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_or
`ifdef SERIAL_OR_REDUCER_FIRST_IDX_EN
  ,
  output logic [CNT_W-1:0] out_first_idx
`endif
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             out_or_q, out_or_d;
  logic             accept;
  logic             last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_beat) state_d = HOLD;
      HOLD:    if (out_valid_q && out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = out_valid_q;
    out_or    = out_or_q;
  end

  // Datapath: accumulator, beat counter and the registered result.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_or_d    = out_or_q;
    if (accept) begin
      if (last_beat) begin
        out_or_d    = acc_q | in_bit;
        out_valid_d = 1'b1;
        acc_d       = 1'b0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_q | in_bit;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (state_q == HOLD && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_or_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_or_q    <= out_or_d;
    end
  end

`ifdef SERIAL_OR_REDUCER_FIRST_IDX_EN
  logic             found_q, found_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;

  // A first 1 on the last beat itself never reaches idx_q, so take cnt_q directly.
  always_comb begin
    found_d     = found_q;
    idx_d       = idx_q;
    first_idx_d = first_idx_q;
    if (accept) begin
      if (last_beat) begin
        if (found_q) begin
          first_idx_d = idx_q;
        end else if (in_bit) begin
          first_idx_d = cnt_q;
        end else begin
          first_idx_d = '0;
        end
        found_d = 1'b0;
        idx_d   = '0;
      end else if (in_bit && !found_q) begin
        found_d = 1'b1;
        idx_d   = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      found_q     <= 1'b0;
      idx_q       <= '0;
      first_idx_q <= '0;
    end else begin
      found_q     <= found_d;
      idx_q       <= idx_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign out_first_idx = first_idx_q;
`endif

endmodule
